draw_sequencer: RTL and testbench
=================================

# draw_sequencer

Frame-level draw scheduler between the sprite FSMs (user, alien, bullet) and the VGA adapter. On each frame tick it clears the playfield with a raster fill. It then grants each active sprite FSM the VGA write port in turn: it raises that FSM's enable, forwards its pixel stream, and waits for its done pulse. It is the only driver of the VGA adapter's x/y/colour/plot inputs.

## Interface
Parameters:
- NUM_CLIENTS, 3: sprite FSMs served, in order; index 0 is drawn first.
- SCREEN_W, 320: clear raster width in pixels.
- SCREEN_H, 240: clear raster height in pixels.
- CLEAR_COLOUR, 3'b000: fill colour.
- TIMEOUT, 1023: maximum cycles to wait for a client's done.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse that starts a frame.
- client_active  in  NUM_CLIENTS  per client; 0 skips that client this frame. Sampled on grant.
- client_enable  out  NUM_CLIENTS  one-hot; drives the sprite FSM's enable.
- client_done  in  NUM_CLIENTS  per-client done pulse.
- client_plot  in  NUM_CLIENTS  per-client pixel-valid strobe.
- client_x  in  9*NUM_CLIENTS  packed; client i occupies bits [9i+8:9i].
- client_y  in  8*NUM_CLIENTS  packed.
- client_colour  in  3*NUM_CLIENTS  packed.
- vga_x  out  9  registered.
- vga_y  out  8  registered.
- vga_colour  out  3  registered.
- vga_plot  out  1  registered.
- busy  out  1  high from frame start to frame end.
- frame_done  out  1  one-cycle pulse when the frame finishes.
- overrun  out  1  sticky; cleared only by reset.
- timeout_fault  out  1  sticky; cleared only by reset.

## Operation
States: IDLE, CLEAR, GRANT, WAIT_DONE, NEXT, FINISH.

- **IDLE**
  - frame_tick moves to CLEAR.
  - busy is 0 only in IDLE.
- **CLEAR**
  - Raster counters cx (0..SCREEN_W-1) and cy (0..SCREEN_H-1) start at (0,0).
  - Each cycle emits one pixel: (cx, cy, CLEAR_COLOUR) with plot=1.
  - cx wraps to 0 at SCREEN_W-1, and cy increments on that wrap.
  - On the cycle that emits (SCREEN_W-1, SCREEN_H-1), the index idx is set to 0 and the state moves to GRANT.
- **GRANT**
  - If client_active[idx]=0, go to NEXT with no enable.
  - Otherwise clear the watchdog counter and go to WAIT_DONE.
- **WAIT_DONE**
  - client_enable[idx]=1; all other enable bits are 0.
  - The selected client's x/y/colour/plot are forwarded to the VGA outputs.
  - On client_done[idx]=1, go to NEXT. That cycle's pixel is still forwarded.
  - If the watchdog reaches TIMEOUT before done, set timeout_fault and go to NEXT.
- **NEXT**
  - If idx=NUM_CLIENTS-1, go to FINISH.
  - Otherwise increment idx and go to GRANT.
- **FINISH**
  - Pulse frame_done, then return to IDLE.

Rules:
- client_enable is a Moore output of state/idx: it drops the cycle after done is sampled. Clients need at least 2 cycles from done back to their plot-wait state, so no client replots.
- done, plot and pixel data from non-selected clients are ignored.
- frame_tick while busy sets overrun and is dropped; ticks are not queued.
- frame_tick on the same cycle as FINISH is honoured as a new frame next cycle (IDLE→CLEAR), with no overrun.

## Timing
Reset values:
- All outputs are 0; state is IDLE; idx=0; cx=cy=0.
- Reset asserted mid-frame aborts within one cycle. The VGA outputs then read 0, including vga_plot=0.

Latency:
- VGA outputs lag their source (raster or client) by exactly 1 cycle.
- First clear pixel: vga_plot rises 2 cycles after the frame_tick cycle.
- Clear phase lasts SCREEN_W*SCREEN_H = 76800 cycles.
- Inactive client: 2 cycles (GRANT, NEXT).
- Active client: enable rises 1 cycle after GRANT.
- Frame with every client inactive: frame_done follows frame_tick by 76800 + 2*NUM_CLIENTS + 2 cycles.

Watchdog:
- Counter width is clog2(TIMEOUT+1).
- It saturates and does not wrap.

## Structure
- Package draw_pkg holds:
  - the state enum,
  - coordinate widths (X_W=9, Y_W=8, COL_W=3),
  - SCREEN_W/SCREEN_H defaults,
  - the CLEAR_COLOUR constant.
- Sub-module draw_clear_raster:
  - ports: start, step, cx, cy, last;
  - a reusable x/y raster counter.
- Client mux, watchdog and FSM live in the top module.

## Test plan
1. **Clear raster:** frame_tick with all client_active=0.
   - vga_plot high for exactly 76800 consecutive cycles.
   - First pixel (0,0), pixel 320 is (0,1), last pixel (319,239), colour 000.
   - frame_done 76800+8 cycles after the tick.
2. **Single client:** client 0 is a model emitting 560 plot pixels then done.
   - All pixels appear on vga_* one cycle later, in order.
   - client_enable[0] falls the cycle after done.
   - The model does not replot.
3. **Order and skip:** client_active=3'b101.
   - Enables appear as 001, then 100.
   - Client 1 gets no enable; its plot pulses never reach vga_plot.
4. **Timeout:** client 2 never asserts done.
   - After TIMEOUT cycles in WAIT_DONE, timeout_fault=1.
   - frame_done still pulses.
5. **Overrun:** frame_tick mid-clear sets overrun=1, and the frame still completes. A tick in the same cycle as FINISH starts a new frame with overrun unchanged.
6. **Reset mid-frame:** assert reset during client 1's grant.
   - Next cycle: all outputs 0, state IDLE.
   - The next frame_tick starts a clean frame from (0,0).

Source files
------------

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types and constants for the frame draw scheduler
package draw_pkg;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    localparam logic [COL_W-1:0] CLEAR_COLOUR_DEF = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GRANT,
        S_WAIT_DONE,
        S_NEXT,
        S_FINISH
    } state_e;

endpackage

// File: rtl/draw_clear_raster.sv
// rtl/draw_clear_raster.sv - x/y raster counter walking the screen row by row
module draw_clear_raster
    import draw_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           step,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);

    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic           row_end;

    assign row_end = (cx_q == X_W'(SCREEN_W - 1));
    assign last    = row_end && (cy_q == Y_W'(SCREEN_H - 1));
    assign cx      = cx_q;
    assign cy      = cy_q;

    // Advance one pixel per step; the final pixel wraps both axes back to the origin.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (start) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step) begin
            if (row_end) begin
                cx_d = '0;
                cy_d = last ? '0 : cy_q + Y_W'(1);
            end else begin
                cx_d = cx_q + X_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - per-frame clear then round-robin VGA port grant to sprite FSMs
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int               NUM_CLIENTS  = 3,
    parameter int               SCREEN_W     = SCREEN_W_DEF,
    parameter int               SCREEN_H     = SCREEN_H_DEF,
    parameter logic [COL_W-1:0] CLEAR_COLOUR = CLEAR_COLOUR_DEF,
    parameter int               TIMEOUT      = 1023
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic [NUM_CLIENTS-1:0]         client_active,
    output logic [NUM_CLIENTS-1:0]         client_enable,
    input  logic [NUM_CLIENTS-1:0]         client_done,
    input  logic [NUM_CLIENTS-1:0]         client_plot,
    input  logic [X_W*NUM_CLIENTS-1:0]     client_x,
    input  logic [Y_W*NUM_CLIENTS-1:0]     client_y,
    input  logic [COL_W*NUM_CLIENTS-1:0]   client_colour,
    output logic [X_W-1:0]                 vga_x,
    output logic [Y_W-1:0]                 vga_y,
    output logic [COL_W-1:0]               vga_colour,
    output logic                           vga_plot,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun,
    output logic                           timeout_fault
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
    logic [X_W-1:0]    vga_x_q, vga_x_d;
    logic [Y_W-1:0]    vga_y_q, vga_y_d;
    logic [COL_W-1:0]  vga_colour_q, vga_colour_d;
    logic              vga_plot_q, vga_plot_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic              timeout_fault_q, timeout_fault_d;

    logic              raster_start, raster_last;
    logic [X_W-1:0]    cx;
    logic [Y_W-1:0]    cy;

    logic              sel_active, sel_done, sel_plot;
    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic [COL_W-1:0]  sel_colour;

    draw_clear_raster #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .start (raster_start),
        .step  (state_q == S_CLEAR),
        .cx    (cx),
        .cy    (cy),
        .last  (raster_last)
    );

    // Pick out the granted client's signals; everyone else is ignored.
    always_comb begin
        sel_active = 1'b0;
        sel_done   = 1'b0;
        sel_plot   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_active = client_active[i];
                sel_done   = client_done[i];
                sel_plot   = client_plot[i];
                sel_x      = client_x[X_W*i +: X_W];
                sel_y      = client_y[Y_W*i +: Y_W];
                sel_colour = client_colour[COL_W*i +: COL_W];
            end
        end
    end

    // Enable is a pure decode of state and index so it drops right after done is taken.
    always_comb begin
        client_enable = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            client_enable[i] = (state_q == S_WAIT_DONE) && (idx_q == IDX_W'(i));
        end
    end

    assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

    // Frame sequencing, pixel source selection, watchdog and sticky fault flags.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        wd_d            = wd_q;
        vga_x_d         = '0;
        vga_y_d         = '0;
        vga_colour_d    = '0;
        vga_plot_d      = 1'b0;
        frame_done_d    = 1'b0;
        overrun_d       = overrun_q;
        timeout_fault_d = timeout_fault_q;
        raster_start    = 1'b0;

        // A tick landing in FINISH is accepted as the next frame, not an overrun.
        if (frame_tick && state_q != S_IDLE && state_q != S_FINISH) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    raster_start = 1'b1;
                    state_d      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                vga_x_d      = cx;
                vga_y_d      = cy;
                vga_colour_d = CLEAR_COLOUR;
                vga_plot_d   = 1'b1;
                if (raster_last) begin
                    idx_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (sel_active) begin
                    wd_d    = '0;
                    state_d = S_WAIT_DONE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WAIT_DONE: begin
                vga_x_d      = sel_x;
                vga_y_d      = sel_y;
                vga_colour_d = sel_colour;
                vga_plot_d   = sel_plot;
                wd_d         = wd_inc;
                if (sel_done) begin
                    state_d = S_NEXT;
                end else if (wd_inc == WD_MAX) begin
                    timeout_fault_d = 1'b1;
                    state_d         = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_W'(NUM_CLIENTS - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_GRANT;
                end
            end
            S_FINISH: begin
                frame_done_d = 1'b1;
                if (frame_tick) begin
                    raster_start = 1'b1;
                    state_d      = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            wd_q            <= '0;
            vga_x_q         <= '0;
            vga_y_q         <= '0;
            vga_colour_q    <= '0;
            vga_plot_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            overrun_q       <= 1'b0;
            timeout_fault_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            wd_q            <= wd_d;
            vga_x_q         <= vga_x_d;
            vga_y_q         <= vga_y_d;
            vga_colour_q    <= vga_colour_d;
            vga_plot_q      <= vga_plot_d;
            frame_done_q    <= frame_done_d;
            overrun_q       <= overrun_d;
            timeout_fault_q <= timeout_fault_d;
        end
    end

    assign vga_x         = vga_x_q;
    assign vga_y         = vga_y_q;
    assign vga_colour    = vga_colour_q;
    assign vga_plot      = vga_plot_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;
    assign timeout_fault = timeout_fault_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb/tb_draw_sequencer.sv - directed self-checking bench for draw_sequencer
module tb_draw_sequencer;

    localparam int W    = 20;
    localparam int H    = 6;
    localparam int N    = 3;
    localparam int NPIX = W * H;
    localparam int TMO  = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [2:0]  client_active, client_enable, client_done, client_plot;
    logic [26:0] client_x;
    logic [23:0] client_y;
    logic [8:0]  client_colour;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy, frame_done, overrun, timeout_fault;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    draw_sequencer #(
        .NUM_CLIENTS (N),
        .SCREEN_W    (W),
        .SCREEN_H    (H),
        .TIMEOUT     (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .client_active (client_active),
        .client_enable (client_enable),
        .client_done   (client_done),
        .client_plot   (client_plot),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .timeout_fault (timeout_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int i, input logic p, input logic [8:0] x,
                           input logic [7:0] y, input logic [2:0] c);
        client_plot[i]          = p;
        client_x[9*i +: 9]      = x;
        client_y[8*i +: 8]      = y;
        client_colour[3*i +: 3] = c;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_en(input logic [2:0] v, input int max);
        int n = 0;
        while (client_enable !== v && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic wait_fd(input int max);
        int n = 0;
        while (frame_done !== 1'b1 && n < max) begin
            step();
            n++;
        end
    endtask

    initial begin
        int t0, t1, errs, nseq, en1, n0, n1, n2, c0, c2, nen;
        logic [2:0] seq [0:3];
        logic [2:0] last_en;

        reset = 1'b1; frame_tick = 1'b0;
        client_active = '0; client_done = '0; client_plot = '0;
        client_x = '0; client_y = '0; client_colour = '0;
        repeat (3) step();
        chk("reset_outputs", {client_enable, vga_x, vga_y, vga_colour, vga_plot,
                              busy, frame_done, overrun, timeout_fault}, 0);
        reset = 1'b0;
        step();

        // 1: clear raster with every client inactive
        t0 = cyc;
        pulse_tick();
        chk("t1_busy", busy, 1);
        chk("t1_plot_pre", vga_plot, 0);
        errs = 0;
        for (int p = 0; p < NPIX; p++) begin
            step();
            if (p == 0)        chk("t1_first_xy", {vga_x, vga_y}, {9'd0, 8'd0});
            if (p == W)        chk("t1_row1_xy",  {vga_x, vga_y}, {9'd0, 8'd1});
            if (p == NPIX - 1) chk("t1_last_xy",  {vga_x, vga_y}, {9'(W - 1), 8'(H - 1)});
            if (!(vga_plot === 1'b1 && vga_x === 9'(p % W) && vga_y === 8'(p / W)
                  && vga_colour === 3'b000)) errs++;
        end
        chk("t1_pix_errs", errs, 0);
        step();
        chk("t1_plot_after", vga_plot, 0);
        wait_fd(20);
        chk("t1_done_seen", frame_done, 1);
        chk("t1_done_lat", cyc - t0, NPIX + 8);
        step();
        chk("t1_done_pulse", {frame_done, busy}, 0);

        // 2: single client streaming 560 pixels, done on the last one
        client_active = 3'b001;
        t0 = cyc;
        pulse_tick();
        wait_en(3'b001, NPIX + 20);
        chk("t2_grant", client_enable, 3'b001);
        chk("t2_en_lat", cyc - t0, NPIX + 2);
        errs = 0;
        for (int k = 0; k < 560; k++) begin
            set_pix(0, 1'b1, 9'(k % 320), 8'(k / 320), 3'(k % 8));
            if (k == 559) client_done[0] = 1'b1;
            step();
            if (k < 559 && client_enable !== 3'b001) errs++;
            if (!(vga_plot === 1'b1 && vga_x === 9'(k % 320) && vga_y === 8'(k / 320)
                  && vga_colour === 3'(k % 8))) errs++;
        end
        chk("t2_pix_errs", errs, 0);
        chk("t2_en_fall", client_enable, 0);
        client_done[0] = 1'b0;
        set_pix(0, 1'b0, 9'd0, 8'd0, 3'd0);
        errs = 0;
        for (int k = 0; k < 20 && frame_done !== 1'b1; k++) begin
            step();
            if (vga_plot !== 1'b0) errs++;
        end
        chk("t2_no_replot", errs, 0);
        chk("t2_done_seen", frame_done, 1);

        // 3: order and skip with client_active = 101
        client_active = 3'b101;
        set_pix(0, 1'b1, 9'd100, 8'd1, 3'd1);
        set_pix(1, 1'b1, 9'd300, 8'd2, 3'd7);
        set_pix(2, 1'b1, 9'd200, 8'd3, 3'd2);
        client_done[1] = 1'b1;
        pulse_tick();
        nseq = 0; en1 = 0; n0 = 0; n1 = 0; n2 = 0; c0 = 0; c2 = 0; last_en = '0;
        for (int k = 0; k < NPIX + 40 && frame_done !== 1'b1; k++) begin
            step();
            if (client_enable !== 3'b000 && client_enable !== last_en && nseq < 4) begin
                seq[nseq] = client_enable;
                nseq++;
                last_en = client_enable;
            end
            if (client_enable[1]) en1++;
            if (vga_plot && vga_x == 9'd100) n0++;
            if (vga_plot && vga_x == 9'd300) n1++;
            if (vga_plot && vga_x == 9'd200) n2++;
            c0 = client_enable[0] ? c0 + 1 : 0;
            c2 = client_enable[2] ? c2 + 1 : 0;
            client_done[0] = (c0 >= 3);
            client_done[2] = (c2 >= 3);
        end
        chk("t3_done_seen", frame_done, 1);
        chk("t3_nseq", nseq, 2);
        chk("t3_seq0", seq[0], 3'b001);
        chk("t3_seq1", seq[1], 3'b100);
        chk("t3_en1", en1, 0);
        chk("t3_pix0", n0, 3);
        chk("t3_pix1", n1, 0);
        chk("t3_pix2", n2, 3);
        client_done = '0;
        client_plot = '0;

        // 4: client 2 never finishes
        client_active = 3'b100;
        pulse_tick();
        wait_en(3'b100, NPIX + 20);
        chk("t4_grant", client_enable, 3'b100);
        chk("t4_fault_pre", timeout_fault, 0);
        nen = 1;
        while (client_enable === 3'b100 && nen < TMO + 10) begin
            step();
            if (client_enable === 3'b100) nen++;
        end
        chk("t4_en_cycles", nen, TMO);
        chk("t4_fault", timeout_fault, 1);
        wait_fd(10);
        chk("t4_done_seen", frame_done, 1);

        // 5: tick on FINISH starts next frame cleanly, mid-clear tick overruns
        client_active = 3'b000;
        step();
        chk("t5_ovr_pre", overrun, 0);
        t0 = cyc;
        pulse_tick();
        while (cyc < t0 + NPIX + 7) step();
        chk("t5_in_finish", {busy, frame_done}, 2'b10);
        t1 = cyc;
        pulse_tick();
        chk("t5_fin_tick", {frame_done, busy, overrun}, 3'b110);
        step();
        chk("t5_restart_px", {vga_plot, vga_x, vga_y}, {1'b1, 9'd0, 8'd0});
        repeat (5) step();
        pulse_tick();
        chk("t5_overrun", overrun, 1);
        wait_fd(NPIX + 20);
        chk("t5_done_seen", frame_done, 1);
        chk("t5_done_lat", cyc - t1, NPIX + 8);

        // 6: reset while client 1 holds the port
        client_active = 3'b111;
        client_done[0] = 1'b1;
        set_pix(1, 1'b1, 9'd300, 8'd5, 3'd7);
        pulse_tick();
        wait_en(3'b010, NPIX + 20);
        chk("t6_grant", client_enable, 3'b010);
        step();
        chk("t6_pre_state", {vga_plot, overrun, timeout_fault}, 3'b111);
        reset = 1'b1;
        step();
        chk("t6_reset_outputs", {client_enable, vga_x, vga_y, vga_colour, vga_plot,
                                 busy, frame_done, overrun, timeout_fault}, 0);
        reset = 1'b0;
        client_active = '0;
        client_done = '0;
        client_plot = '0;
        step();
        t0 = cyc;
        pulse_tick();
        chk("t6_plot_pre", vga_plot, 0);
        step();
        chk("t6_first_px", {vga_plot, vga_x, vga_y}, {1'b1, 9'd0, 8'd0});
        wait_fd(NPIX + 20);
        chk("t6_done_lat", cyc - t0, NPIX + 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
